// File: rtl/uart_pkg.sv
// Shared types and frame helpers for the parametrised UART transceiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START_CHK,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_t;

    // Serial bits per frame: start + data + optional parity + stop bits.
    function automatic int frame_bits(
        input int data_bits,
        input int parity,
        input int stop_bits
    );
        return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_xcvr_param_baud.sv
// Baud divider: free-running 0..BAUD_DIV-1 counter with mid-bit and end-of-bit ticks.
module uart_baud_cnt #(
    parameter int BAUD_DIV = 2604
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic half_tick,
    output logic bit_tick
);

    localparam int CW = $clog2(BAUD_DIV);

    logic [CW-1:0] cnt_q;

    assign bit_tick  = (cnt_q == CW'(BAUD_DIV - 1));
    assign half_tick = (cnt_q == CW'(BAUD_DIV / 2 - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || bit_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_xcvr_param.sv
// Full-duplex UART with configurable width, parity and stop bits.
module uart_xcvr_param
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 2604,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 TX,
    output logic                 tx_done,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam bit HAS_PAR = (PARITY != int'(PAR_NONE));
    localparam bit ODD     = (PARITY == int'(PAR_ODD));
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    tx_state_t            tx_state_q;
    logic [DATA_BITS:0]   tx_sh_q;
    logic [3:0]           tx_cnt_q;
    logic                 tx_q;
    logic                 tx_done_q;
    logic                 tx_tick;
    logic                 tx_half_unused;
    logic                 tx_par;

    assign tx_par = (^tx_data) ^ ODD;

    uart_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_tx_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (tx_state_q == TX_IDLE),
        .half_tick (tx_half_unused),
        .bit_tick  (tx_tick)
    );

    // Shift register holds {parity, data}; after the data bits parity sits at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_sh_q    <= '0;
            tx_cnt_q   <= '0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            unique case (tx_state_q)
                TX_IDLE: begin
                    if (trmt) begin
                        tx_sh_q    <= {tx_par, tx_data};
                        tx_cnt_q   <= '0;
                        tx_q       <= 1'b0;
                        tx_done_q  <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        tx_q       <= tx_sh_q[0];
                        tx_sh_q    <= tx_sh_q >> 1;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        if (tx_cnt_q == LAST_DATA) begin
                            tx_cnt_q <= '0;
                            if (HAS_PAR) begin
                                tx_q       <= tx_sh_q[0];
                                tx_state_q <= TX_PAR;
                            end else begin
                                tx_q       <= 1'b1;
                                tx_state_q <= TX_STOP;
                            end
                        end else begin
                            tx_cnt_q <= tx_cnt_q + 1'b1;
                            tx_q     <= tx_sh_q[0];
                            tx_sh_q  <= tx_sh_q >> 1;
                        end
                    end
                end
                TX_PAR: begin
                    if (tx_tick) begin
                        tx_q       <= 1'b1;
                        tx_state_q <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        if (tx_cnt_q == LAST_STOP) begin
                            tx_done_q  <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end else begin
                            tx_cnt_q <= tx_cnt_q + 1'b1;
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign TX      = tx_q;
    assign tx_done = tx_done_q;

    logic rx_s0_q;
    logic rx_s1_q;
    logic rx_prev_q;
    logic rx_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s0_q   <= 1'b1;
            rx_s1_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s0_q   <= RX;
            rx_s1_q   <= rx_s0_q;
            rx_prev_q <= rx_s1_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s1_q;

    rx_state_t            rx_state_q;
    logic [DATA_BITS-1:0] rx_sh_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic [3:0]           rx_cnt_q;
    logic                 rx_par_q;
    logic                 rdy_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 rx_tick;
    logic                 rx_half;
    logic                 rx_clr;
    logic                 rx_perr;

    // Restart the divider on confirmation so later samples land mid-bit.
    assign rx_clr  = (rx_state_q == RX_IDLE) |
                     ((rx_state_q == RX_START_CHK) & rx_half);
    assign rx_perr = HAS_PAR & ((^rx_sh_q) ^ rx_par_q ^ ODD);

    uart_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_rx_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (rx_clr),
        .half_tick (rx_half),
        .bit_tick  (rx_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_cnt_q   <= '0;
            rx_par_q   <= 1'b0;
            rdy_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            if (clr_rdy) begin
                rdy_q  <= 1'b0;
                perr_q <= 1'b0;
                ferr_q <= 1'b0;
            end
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state_q <= RX_START_CHK;
                    end
                end
                RX_START_CHK: begin
                    if (rx_half) begin
                        if (rx_s1_q) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_cnt_q   <= '0;
                            rdy_q      <= 1'b0;
                            perr_q     <= 1'b0;
                            ferr_q     <= 1'b0;
                            rx_state_q <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_sh_q <= {rx_s1_q, rx_sh_q[DATA_BITS-1:1]};
                        if (rx_cnt_q == LAST_DATA) begin
                            rx_cnt_q   <= '0;
                            rx_state_q <= HAS_PAR ? RX_PAR : RX_STOP;
                        end else begin
                            rx_cnt_q <= rx_cnt_q + 1'b1;
                        end
                    end
                end
                RX_PAR: begin
                    if (rx_tick) begin
                        rx_par_q   <= rx_s1_q;
                        rx_state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_data_q  <= rx_sh_q;
                        perr_q     <= rx_perr;
                        ferr_q     <= ~rx_s1_q;
                        rdy_q      <= 1'b1;
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rdy        = rdy_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Directed bench: three transceiver configurations (8N1, 7E1, 9O2) at BAUD_DIV = 16.
module tb_uart_xcvr_param;
    import uart_pkg::*;

    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] trmt = '0;
    logic [2:0] clr = '0;
    logic [2:0] drv = '1;
    logic [2:0] lb = '0;
    logic [8:0] txd = '0;
    int         sel = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    logic       tx_a, done_a, rx_a, rdy_a, perr_a, ferr_a;
    logic [7:0] rxd_a;
    logic       tx_b, done_b, rx_b, rdy_b, perr_b, ferr_b;
    logic [6:0] rxd_b;
    logic       tx_c, done_c, rx_c, rdy_c, perr_c, ferr_c;
    logic [8:0] rxd_c;

    logic       tx_s, done_s, rdy_s, perr_s, ferr_s;
    logic [8:0] rxd_s;

    always #5 clk = ~clk;

    assign rx_a = lb[0] ? tx_a : drv[0];
    assign rx_b = lb[1] ? tx_b : drv[1];
    assign rx_c = lb[2] ? tx_c : drv[2];

    uart_xcvr_param #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .trmt(trmt[0]), .tx_data(txd[7:0]),
        .TX(tx_a), .tx_done(done_a), .RX(rx_a), .clr_rdy(clr[0]),
        .rx_data(rxd_a), .rdy(rdy_a), .parity_err(perr_a), .frame_err(ferr_a)
    );

    uart_xcvr_param #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .trmt(trmt[1]), .tx_data(txd[6:0]),
        .TX(tx_b), .tx_done(done_b), .RX(rx_b), .clr_rdy(clr[1]),
        .rx_data(rxd_b), .rdy(rdy_b), .parity_err(perr_b), .frame_err(ferr_b)
    );

    uart_xcvr_param #(.BAUD_DIV(BD), .DATA_BITS(9), .PARITY(2), .STOP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .trmt(trmt[2]), .tx_data(txd),
        .TX(tx_c), .tx_done(done_c), .RX(rx_c), .clr_rdy(clr[2]),
        .rx_data(rxd_c), .rdy(rdy_c), .parity_err(perr_c), .frame_err(ferr_c)
    );

    always_comb begin
        tx_s   = tx_a;
        done_s = done_a;
        rdy_s  = rdy_a;
        perr_s = perr_a;
        ferr_s = ferr_a;
        rxd_s  = {1'b0, rxd_a};
        case (sel)
            1: begin
                tx_s   = tx_b;
                done_s = done_b;
                rdy_s  = rdy_b;
                perr_s = perr_b;
                ferr_s = ferr_b;
                rxd_s  = {2'b00, rxd_b};
            end
            2: begin
                tx_s   = tx_c;
                done_s = done_c;
                rdy_s  = rdy_c;
                perr_s = perr_c;
                ferr_s = ferr_c;
                rxd_s  = rxd_c;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_clr();
        clr[sel] = 1'b1;
        @(negedge clk);
        clr[sel] = 1'b0;
    endtask

    // Pulse trmt, capture TX mid-bit, and measure trmt-to-tx_done cycles.
    task automatic send(input logic [8:0] d, input int nb, input int retrig,
                        output int lat, output logic [15:0] fr);
        lat = -1;
        fr  = '0;
        txd = d;
        trmt[sel] = 1'b1;
        for (int k = 1; k <= nb * BD + 40; k++) begin
            @(negedge clk);
            trmt[sel] = (k == retrig);
            if (k == retrig) txd = ~d;
            if (k >= 8 && (k - 8) % BD == 0 && (k - 8) / BD < nb)
                fr[(k - 8) / BD] = tx_s;
            if (lat < 0 && done_s) lat = k;
        end
        trmt[sel] = 1'b0;
    endtask

    // Drive a frame (bit 0 = start) onto RX, then one idle bit.
    task automatic drive(input logic [15:0] bits, input int nb, input int clr_at,
                         output int rdy_at, output logic f3, output logic f12);
        rdy_at = -1;
        f3 = 1'b0;
        f12 = 1'b0;
        for (int k = 0; k < (nb + 1) * BD; k++) begin
            drv[sel] = (k / BD < nb) ? bits[k / BD] : 1'b1;
            clr[sel] = (k == clr_at);
            @(negedge clk);
            if (rdy_at < 0 && rdy_s) rdy_at = k;
            if (k == 3) f3 = ferr_s;
            if (k == 12) f12 = ferr_s;
        end
        clr[sel] = 1'b0;
        drv[sel] = 1'b1;
    endtask

    int          lat;
    int          rat;
    int          rat2;
    logic [15:0] fr;
    logic        f3;
    logic        f12;
    logic [7:0]  bytes[3];
    logic [9:0]  frames[3];

    initial begin
        bytes  = '{8'hAA, 8'h44, 8'h00};
        frames = '{10'h354, 10'h288, 10'h200};

        repeat (3) @(negedge clk);
        chk("rst_tx", tx_a, 1);
        chk("rst_done", done_a, 0);
        chk("rst_rdy", rdy_a, 0);
        chk("rst_perr", perr_a, 0);
        chk("rst_ferr", ferr_a, 0);
        chk("rst_rxd", rxd_a, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        sel = 0;
        lb[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send({1'b0, bytes[i]}, 10, -1, lat, fr);
            chk("lb_lat", lat, 161);
            chk("lb_frame", fr, {6'd0, frames[i]});
            chk("lb_rdy", rdy_a, 1);
            chk("lb_rxd", rxd_a, bytes[i]);
            chk("lb_perr", perr_a, 0);
            chk("lb_ferr", ferr_a, 0);
            pulse_clr();
            chk("lb_clr", rdy_a, 0);
        end

        send(9'h05A, 10, 40, lat, fr);
        chk("busy_lat", lat, 161);
        chk("busy_frame", fr, 16'h02B4);
        chk("busy_rxd", rxd_a, 8'h5A);
        pulse_clr();
        repeat (200) @(negedge clk);
        chk("busy_norx", rdy_a, 0);
        chk("busy_txidle", tx_a, 1);

        lb[0] = 1'b0;
        drive({6'd0, 1'b0, 8'h3C, 1'b0}, 10, -1, rat, f3, f12);
        chk("ferr_rdy", rdy_a, 1);
        chk("ferr_flag", ferr_a, 1);
        chk("ferr_rxd", rxd_a, 8'h3C);
        chk("ferr_perr", perr_a, 0);

        drv[0] = 1'b0;
        repeat (BD / 4) @(negedge clk);
        drv[0] = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_rdy", rdy_a, 1);
        chk("glitch_ferr", ferr_a, 1);
        chk("glitch_rxd", rxd_a, 8'h3C);

        drive({6'd0, 1'b1, 8'hC3, 1'b0}, 10, -1, rat, f3, f12);
        chk("ferr_hold", f3, 1);
        chk("ferr_cleared", f12, 0);
        chk("ok_rdy", rdy_a, 1);
        chk("ok_ferr", ferr_a, 0);
        chk("ok_rxd", rxd_a, 8'hC3);

        pulse_clr();
        drive({6'd0, 1'b1, 8'h96, 1'b0}, 10, -1, rat, f3, f12);
        chk("rdy_cycle", rat, 154);
        pulse_clr();
        drive({6'd0, 1'b1, 8'h96, 1'b0}, 10, rat, rat2, f3, f12);
        chk("setwins_rdy", rdy_a, 1);
        chk("setwins_rxd", rxd_a, 8'h96);

        sel = 1;
        lb[1] = 1'b1;
        send(9'h055, 10, -1, lat, fr);
        chk("e_lat", lat, 161);
        chk("e_frame", fr, 16'h02AA);
        chk("e_rdy", rdy_b, 1);
        chk("e_rxd", rxd_b, 7'h55);
        chk("e_perr", perr_b, 0);
        lb[1] = 1'b0;
        drive({6'd0, 1'b1, 1'b1, 7'h55, 1'b0}, 10, -1, rat, f3, f12);
        chk("pe_rdy", rdy_b, 1);
        chk("pe_perr", perr_b, 1);
        chk("pe_rxd", rxd_b, 7'h55);
        chk("pe_ferr", ferr_b, 0);
        pulse_clr();
        chk("pe_clr_rdy", rdy_b, 0);
        chk("pe_clr_perr", perr_b, 0);

        sel = 2;
        lb[2] = 1'b1;
        send(9'h1A5, 13, -1, lat, fr);
        chk("o_lat", lat, 209);
        chk("o_frame", fr, 16'h1B4A);
        chk("o_rxd", rxd_c, 9'h1A5);
        chk("o_perr", perr_c, 0);

        txd = 9'h00F;
        trmt[2] = 1'b1;
        @(negedge clk);
        trmt[2] = 1'b0;
        repeat (103) @(negedge clk);
        chk("mid_tx_low", tx_c, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_tx", tx_c, 1);
        chk("arst_done", done_c, 0);
        chk("arst_rdy", rdy_c, 0);
        chk("arst_rxd", rxd_c, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("post_rdy", rdy_c, 0);
        chk("post_done", done_c, 0);
        chk("post_tx", tx_c, 1);

        send(9'h1A5, 13, -1, lat, fr);
        chk("re_lat", lat, 209);
        chk("re_frame", fr, 16'h1B4A);
        chk("re_rdy", rdy_c, 1);
        chk("re_rxd", rxd_c, 9'h1A5);
        chk("re_perr", perr_c, 0);
        chk("re_ferr", ferr_c, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
